// File: rtl/code_fetch_pkg.sv
// Shared constants, entry type and helpers for the code fetch front end.
package code_fetch_pkg;

    localparam int CF_ADDR_W = 8;
    localparam int CF_DATA_W = 32;
    localparam int CF_DEPTH  = 4;

    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    typedef struct packed {
        logic [31:0]          pc;
        logic [CF_DATA_W-1:0] data;
    } fetch_entry_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == DROP_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/code_fetch_if.sv
// Code memory read port plus the tagged instruction valid/ready stream.
interface code_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();

    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] instr;
    logic [31:0]       instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output mem_rd, mem_addr, instr, instr_pc, instr_valid,
        input  mem_data, instr_ready
    );

    modport slave (
        input  mem_rd, mem_addr, instr, instr_pc, instr_valid,
        output mem_data, instr_ready
    );

endinterface

// File: rtl/code_fetch_fifo.sv
// Small synchronous FIFO of fetch entries with first-word fall-through head.
module code_fetch_fifo
    import code_fetch_pkg::*;
#(
    parameter int  DEPTH   = CF_DEPTH,
    parameter type entry_t = fetch_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  entry_t wdata,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr, rd_ptr;
    entry_t      mem [DEPTH];
    logic        do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (do_push) begin
                mem[wr_ptr[PW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/code_fetch.sv
// Fetch front end: sequence check, code memory read, pending stage, tagged FIFO.
module code_fetch
    import code_fetch_pkg::*;
#(
    parameter int ADDR_W = CF_ADDR_W,
    parameter int DATA_W = CF_DATA_W,
    parameter int DEPTH  = CF_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   count,
    code_fetch_if.master  bus,
    output logic          oob,
    output logic          overflow,
    output logic [15:0]   drop_cnt
);

    typedef struct packed {
        logic [31:0]       pc;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam logic [32:0] ADDR_SPAN = 33'd1 << ADDR_W;

    logic [31:0] last_count, pend_pc;
    logic        have_last, pend_valid;
    logic        disc, in_range, push, pop, drop, full, empty;
    entry_t      head, wdata;

    // 32-bit wrap: 0xFFFFFFFF -> 0 counts as continuous.
    assign disc     = have_last && (count != last_count + 32'd1);
    assign in_range = ({1'b0, count} < ADDR_SPAN);

    assign bus.mem_rd   = !reset && in_range;
    assign bus.mem_addr = count[ADDR_W-1:0];

    // The word landing during a discontinuity belongs to the old stream.
    assign push  = pend_valid && !disc;
    assign pop   = bus.instr_valid && bus.instr_ready;
    assign drop  = push && full && !pop;
    assign wdata = '{pc: pend_pc, data: bus.mem_data};

    assign bus.instr_valid = !empty && !disc;
    assign bus.instr       = head.data;
    assign bus.instr_pc    = head.pc;

    code_fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (disc),
        .wdata (wdata),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            last_count <= '0;
            have_last  <= 1'b0;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
            oob        <= 1'b0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            last_count <= count;
            have_last  <= 1'b1;
            pend_valid <= bus.mem_rd;
            pend_pc    <= count;
            if (!in_range) oob <= 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                drop_cnt <= sat_inc16(drop_cnt);
            end
        end
    end

endmodule

// File: tb/tb_code_fetch.sv
// Directed bench for code_fetch: count driven on negedge, outputs sampled 1ns later.
module tb_code_fetch;
    import code_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] count = '0;
    logic        oob, overflow;
    logic [15:0] drop_cnt;
    logic [31:0] mem_q = '0;
    int          total = 0;
    int          bad = 0;

    code_fetch_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    code_fetch #(.ADDR_W(8), .DATA_W(32), .DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .count    (count),
        .bus      (bus.master),
        .oob      (oob),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Code memory model: word at address a holds a*3, one cycle read latency.
    assign bus.mem_data = mem_q;
    always @(posedge clk) if (bus.mem_rd) mem_q <= 32'(bus.mem_addr) * 32'd3;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input logic [31:0] c, input logic rdy);
        @(negedge clk);
        reset = 1'b0;
        count = c;
        bus.instr_ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        count = '0;
        bus.instr_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        #1;
        total++;
        if ({bus.mem_rd, bus.instr_valid, oob, overflow} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got rd/vld/oob/ovf=%b want 0000",
                     {bus.mem_rd, bus.instr_valid, oob, overflow});
        end
        total++;
        if (drop_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_drop got %0d want 0", drop_cnt);
        end
        total++;
        if ({bus.instr_pc, bus.instr} !== 64'd0) begin
            bad++;
            $display("FAIL reset_head got pc=%0h instr=%0h want 0 0", bus.instr_pc, bus.instr);
        end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 8; k++) begin
            cyc(32'(k), 1'b1);
            if (k == 0) begin
                total++;
                if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 8'd0}) begin
                    bad++;
                    $display("FAIL stream_rd got rd=%b addr=%0d want 1 0", bus.mem_rd, bus.mem_addr);
                end
            end
            total++;
            if (k < 2) begin
                if (bus.instr_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL stream_lat k=%0d got valid=%b want 0", k, bus.instr_valid);
                end
            end else if ({bus.instr_valid, bus.instr_pc, bus.instr} !==
                         {1'b1, 32'(k - 2), 32'(3 * (k - 2))}) begin
                bad++;
                $display("FAIL stream_word k=%0d got v=%b pc=%0d instr=%0d want 1 %0d %0d",
                         k, bus.instr_valid, bus.instr_pc, bus.instr, k - 2, 3 * (k - 2));
            end
        end
        total++;
        if ({overflow, drop_cnt} !== 17'd0) begin
            bad++;
            $display("FAIL stream_nodrop got ovf=%b drop=%0d want 0 0", overflow, drop_cnt);
        end
    endtask

    task automatic test_backpressure();
        int exp_pc [6] = '{0, 1, 2, 3, 10, 11};
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            cyc(32'(k), 1'b0);
            if (k >= 2) begin
                total++;
                if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 32'd0, 32'd0}) begin
                    bad++;
                    $display("FAIL bp_hold k=%0d got v=%b pc=%0d instr=%0d want 1 0 0",
                             k, bus.instr_valid, bus.instr_pc, bus.instr);
                end
            end
            if (k == 5) begin
                total++;
                if (overflow !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_ovf_early got %b want 0", overflow);
                end
            end
            if (k == 6) begin
                total++;
                if ({overflow, drop_cnt} !== {1'b1, 16'd1}) begin
                    bad++;
                    $display("FAIL bp_first_drop got ovf=%b drop=%0d want 1 1", overflow, drop_cnt);
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            cyc(32'(11 + i), 1'b1);
            total++;
            if ({bus.instr_valid, bus.instr_pc, bus.instr} !==
                {1'b1, 32'(exp_pc[i]), 32'(3 * exp_pc[i])}) begin
                bad++;
                $display("FAIL bp_order i=%0d got v=%b pc=%0d instr=%0d want 1 %0d %0d",
                         i, bus.instr_valid, bus.instr_pc, bus.instr, exp_pc[i], 3 * exp_pc[i]);
            end
            if (i == 0 || i == 5) begin
                total++;
                if (drop_cnt !== 16'd6) begin
                    bad++;
                    $display("FAIL bp_drop_cnt i=%0d got %0d want 6", i, drop_cnt);
                end
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        cyc(32'd5, 1'b0);
        cyc(32'd6, 1'b0);
        total++;
        if (bus.instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_pre got valid=%b want 0", bus.instr_valid);
        end
        cyc(32'd7, 1'b0);
        total++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 32'd5, 32'd15}) begin
            bad++;
            $display("FAIL flush_head got v=%b pc=%0d instr=%0d want 1 5 15",
                     bus.instr_valid, bus.instr_pc, bus.instr);
        end
        cyc(32'd0, 1'b1);
        total++;
        if ({bus.instr_valid, bus.mem_rd, bus.mem_addr} !== {1'b0, 1'b1, 8'd0}) begin
            bad++;
            $display("FAIL flush_disc got v=%b rd=%b addr=%0d want 0 1 0",
                     bus.instr_valid, bus.mem_rd, bus.mem_addr);
        end
        cyc(32'd1, 1'b1);
        total++;
        if (bus.instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_empty got valid=%b want 0", bus.instr_valid);
        end
        cyc(32'd2, 1'b1);
        total++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 32'd0, 32'd0}) begin
            bad++;
            $display("FAIL flush_resume0 got v=%b pc=%0d instr=%0d want 1 0 0",
                     bus.instr_valid, bus.instr_pc, bus.instr);
        end
        cyc(32'd3, 1'b1);
        total++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 32'd1, 32'd3}) begin
            bad++;
            $display("FAIL flush_resume1 got v=%b pc=%0d instr=%0d want 1 1 3",
                     bus.instr_valid, bus.instr_pc, bus.instr);
        end
    endtask

    task automatic test_oob();
        do_reset();
        cyc(32'd254, 1'b1);
        total++;
        if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 8'd254}) begin
            bad++;
            $display("FAIL oob_rd_in got rd=%b addr=%0d want 1 254", bus.mem_rd, bus.mem_addr);
        end
        cyc(32'd255, 1'b1);
        cyc(32'd256, 1'b1);
        total++;
        if ({bus.mem_rd, oob} !== 2'b00) begin
            bad++;
            $display("FAIL oob_rd_out got rd=%b oob=%b want 0 0", bus.mem_rd, oob);
        end
        total++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 32'd254, 32'd762}) begin
            bad++;
            $display("FAIL oob_w254 got v=%b pc=%0d instr=%0d want 1 254 762",
                     bus.instr_valid, bus.instr_pc, bus.instr);
        end
        cyc(32'd257, 1'b1);
        total++;
        if ({bus.mem_rd, oob} !== 2'b01) begin
            bad++;
            $display("FAIL oob_sticky got rd=%b oob=%b want 0 1", bus.mem_rd, oob);
        end
        total++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 32'd255, 32'd765}) begin
            bad++;
            $display("FAIL oob_w255 got v=%b pc=%0d instr=%0d want 1 255 765",
                     bus.instr_valid, bus.instr_pc, bus.instr);
        end
        cyc(32'd258, 1'b1);
        total++;
        if (bus.instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL oob_no_push got valid=%b pc=%0d want 0", bus.instr_valid, bus.instr_pc);
        end
    endtask

    task automatic test_reset_midstream();
        cyc(32'd0, 1'b0);
        cyc(32'd1, 1'b0);
        cyc(32'd2, 1'b0);
        cyc(32'd3, 1'b0);
        total++;
        if ({bus.instr_valid, bus.instr_pc, oob} !== {1'b1, 32'd0, 1'b1}) begin
            bad++;
            $display("FAIL mid_pre got v=%b pc=%0d oob=%b want 1 0 1",
                     bus.instr_valid, bus.instr_pc, oob);
        end
        @(negedge clk);
        reset = 1'b1;
        count = 32'd4;
        @(negedge clk);
        reset = 1'b0;
        count = 32'd0;
        bus.instr_ready = 1'b1;
        #1;
        total++;
        if ({bus.instr_valid, oob, overflow, drop_cnt} !== 19'd0) begin
            bad++;
            $display("FAIL mid_cleared got v=%b oob=%b ovf=%b drop=%0d want 0 0 0 0",
                     bus.instr_valid, oob, overflow, drop_cnt);
        end
        total++;
        if ({bus.instr_pc, bus.instr} !== 64'd0) begin
            bad++;
            $display("FAIL mid_head got pc=%0d instr=%0d want 0 0", bus.instr_pc, bus.instr);
        end
        cyc(32'd1, 1'b1);
        total++;
        if (bus.instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_stale got valid=%b pc=%0d want 0", bus.instr_valid, bus.instr_pc);
        end
        cyc(32'd2, 1'b1);
        total++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 32'd0, 32'd0}) begin
            bad++;
            $display("FAIL mid_w0 got v=%b pc=%0d instr=%0d want 1 0 0",
                     bus.instr_valid, bus.instr_pc, bus.instr);
        end
        cyc(32'd3, 1'b1);
        total++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 32'd1, 32'd3}) begin
            bad++;
            $display("FAIL mid_w1 got v=%b pc=%0d instr=%0d want 1 1 3",
                     bus.instr_valid, bus.instr_pc, bus.instr);
        end
    endtask

    initial begin
        bus.instr_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_oob();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
